dma_priority_arbiter: RTL and testbench

Request arbiter and bus-hold sequencer for the four-channel DMA controller. Resolves active, unmasked DREQ lines under fixed or rotating priority. Runs the HRQ/HLDA hold handshake with the CPU, then issues a one-hot DACK to the winning channel. Holds the grant until the timing-control block signals end of service, and maintains the priorityOrder vector consumed by the rest of the controller.

---
 rtl/dma_priority_arbiter_if.sv | 25 ++
 rtl/dma_priority_arbiter.sv | 143 ++++++++++++++
 tb/tb_dma_priority_arbiter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/dma_priority_arbiter_if.sv
// Request/grant bundle between the DMA priority arbiter and the rest of the controller.
// Signal names follow the controller's established port names.
interface dma_priority_arbiter_if;
  logic [3:0] DREQ;
  logic [3:0] maskReg;
  logic       priorityType;
  logic       HLDA;
  logic       serviceDone;
  logic       EOP_N;
  logic       HRQ;
  logic [3:0] DACK;
  logic       grantValid;
  logic [1:0] grantChannel;
  logic [7:0] priorityOrder;

  modport slave (
    input  DREQ, maskReg, priorityType, HLDA, serviceDone, EOP_N,
    output HRQ, DACK, grantValid, grantChannel, priorityOrder
  );

  modport master (
    output DREQ, maskReg, priorityType, HLDA, serviceDone, EOP_N,
    input  HRQ, DACK, grantValid, grantChannel, priorityOrder
  );
endinterface

// File: rtl/dma_priority_arbiter.sv
// Four-channel DMA request arbiter: fixed/rotating priority, HRQ/HLDA hold handshake,
// one-hot DACK held until end of service, and the priority order vector.
module dma_priority_arbiter #(
  parameter bit DREQ_ACTIVE_HIGH = 1'b1,
  parameter bit DACK_ACTIVE_HIGH = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  dma_priority_arbiter_if.slave bus
);

  localparam logic [7:0] FIXED_ORDER = 8'b11_10_01_00;
  localparam logic [3:0] DACK_IDLE   = DACK_ACTIVE_HIGH ? 4'b0000 : 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_GRANT,
    S_RELEASE
  } state_t;

  state_t     r_state;
  logic       r_hrq;
  logic [3:0] r_dack;
  logic       r_grant_valid;
  logic [1:0] r_grant_channel;
  logic [7:0] r_priority_order;

  logic [3:0] w_req_eff;
  logic       w_any_req;
  logic       w_done;
  logic [1:0] w_winner;
  logic [7:0] w_rotated_order;
  logic [1:0] w_next1;
  logic [1:0] w_next2;
  logic [1:0] w_next3;

  assign w_req_eff = (DREQ_ACTIVE_HIGH ? bus.DREQ : ~bus.DREQ) & ~bus.maskReg;
  assign w_any_req = |w_req_eff;
  assign w_done    = bus.serviceDone | ~bus.EOP_N;

  // Scan from lowest to highest priority so the highest-priority requester is written last.
  always_comb begin
    w_winner = r_priority_order[1:0];
    for (int i = 3; i >= 0; i--) begin
      if (w_req_eff[r_priority_order[2*i +: 2]]) w_winner = r_priority_order[2*i +: 2];
    end
  end

  // Served channel drops to lowest; its cyclic successors move up in order.
  assign w_next1         = r_grant_channel + 2'd1;
  assign w_next2         = r_grant_channel + 2'd2;
  assign w_next3         = r_grant_channel + 2'd3;
  assign w_rotated_order = {r_grant_channel, w_next3, w_next2, w_next1};

  function automatic logic [3:0] dack_for(input logic [1:0] ch);
    logic [3:0] one_hot;
    one_hot = 4'b0001 << ch;
    return DACK_ACTIVE_HIGH ? one_hot : ~one_hot;
  endfunction

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values; the async reset branch drops DACK/HRQ without waiting for CLK.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state          <= S_IDLE;
      r_hrq            <= 1'b0;
      r_dack           <= DACK_IDLE;
      r_grant_valid    <= 1'b0;
      r_grant_channel  <= 2'b00;
      r_priority_order <= FIXED_ORDER;
    end else begin
      if (!bus.priorityType) begin
        r_priority_order <= FIXED_ORDER;
      end else if (r_state == S_GRANT && w_done) begin
        r_priority_order <= w_rotated_order;
      end

      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state <= S_REQ;
            r_hrq   <= 1'b1;
          end
        end

        S_REQ: begin
          if (bus.HLDA && w_any_req) begin
            r_state         <= S_GRANT;
            r_dack          <= dack_for(w_winner);
            r_grant_valid   <= 1'b1;
            r_grant_channel <= w_winner;
          end else if (!w_any_req) begin
            r_state <= S_IDLE;
            r_hrq   <= 1'b0;
          end
        end

        S_GRANT: begin
          // Completion takes precedence over a simultaneous HLDA drop.
          if (w_done) begin
            r_state       <= S_RELEASE;
            r_dack        <= DACK_IDLE;
            r_grant_valid <= 1'b0;
          end else if (!bus.HLDA) begin
            r_dack        <= DACK_IDLE;
            r_grant_valid <= 1'b0;
            if (w_any_req) begin
              r_state <= S_REQ;
            end else begin
              r_state <= S_IDLE;
              r_hrq   <= 1'b0;
            end
          end
        end

        S_RELEASE: begin
          if (bus.HLDA && w_any_req) begin
            r_state         <= S_GRANT;
            r_dack          <= dack_for(w_winner);
            r_grant_valid   <= 1'b1;
            r_grant_channel <= w_winner;
          end else begin
            r_state <= S_IDLE;
            r_hrq   <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_hrq   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.HRQ           = r_hrq;
  assign bus.DACK          = r_dack;
  assign bus.grantValid    = r_grant_valid;
  assign bus.grantChannel  = r_grant_channel;
  assign bus.priorityOrder = r_priority_order;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus a randomized
// run compared every cycle against a list-based model of the arbitration rules.
module tb_dma_priority_arbiter;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  dma_priority_arbiter_if bus ();

  dma_priority_arbiter dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0=idle 1=requesting 2=granted 3=releasing; m_ord lists channels, highest first.
  int m_phase;
  int m_ord[4];
  int m_ch;

  always @(posedge clk or negedge rst_n) begin : model
    logic [3:0] req;
    int         win;
    bit         done;
    int         prev;
    if (!rst_n) begin
      m_phase = 0;
      m_ch    = 0;
      for (int i = 0; i < 4; i++) m_ord[i] = i;
    end else begin
      req  = bus.DREQ & ~bus.maskReg;
      win  = -1;
      for (int i = 0; i < 4; i++) if (win < 0 && req[m_ord[i]]) win = m_ord[i];
      done = bus.serviceDone || !bus.EOP_N;
      prev = m_phase;
      case (m_phase)
        0: if (req != 0) m_phase = 1;
        1: if (bus.HLDA && req != 0) begin m_phase = 2; m_ch = win; end
           else if (req == 0) m_phase = 0;
        2: if (done) m_phase = 3;
           else if (!bus.HLDA) m_phase = (req != 0) ? 1 : 0;
        default: if (bus.HLDA && req != 0) begin m_phase = 2; m_ch = win; end
                 else m_phase = 0;
      endcase
      if (!bus.priorityType) begin
        for (int i = 0; i < 4; i++) m_ord[i] = i;
      end else if (prev == 2 && done) begin
        for (int i = 0; i < 4; i++) m_ord[i] = (m_ch + 1 + i) % 4;
      end
    end
  end

  function automatic logic [7:0] model_order();
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[2*i +: 2] = 2'(m_ord[i]);
    return r;
  endfunction

  always @(negedge clk) begin : compare
    check("cmp_hrq",   {31'd0, bus.HRQ},        {31'd0, m_phase != 0});
    check("cmp_dack",  {28'd0, bus.DACK},       (m_phase == 2) ? (32'd1 << m_ch) : 32'd0);
    check("cmp_valid", {31'd0, bus.grantValid}, {31'd0, m_phase == 2});
    check("cmp_chan",  {30'd0, bus.grantChannel}, 32'(m_ch));
    check("cmp_order", {24'd0, bus.priorityOrder}, {24'd0, model_order()});
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_grant(input int budget);
    for (int i = 0; i < budget && !bus.grantValid; i++) step();
    check("grant_wait", {31'd0, bus.grantValid}, 32'd1);
  endtask

  task automatic quiesce();
    bus.DREQ        = 4'b0000;
    bus.serviceDone = 1'b1;
    step();
    bus.serviceDone = 1'b0;
    bus.HLDA        = 1'b0;
    bus.maskReg     = 4'b0000;
    bus.EOP_N       = 1'b1;
    step(2);
  endtask

  logic [3:0] rot_seq [5];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rot_seq[0] = 4'b0001; rot_seq[1] = 4'b0010; rot_seq[2] = 4'b0100;
    rot_seq[3] = 4'b1000; rot_seq[4] = 4'b0001;
    bus.DREQ = 4'b0000; bus.maskReg = 4'b0000; bus.priorityType = 1'b0;
    bus.HLDA = 1'b0; bus.serviceDone = 1'b0; bus.EOP_N = 1'b1;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    check("rst_hrq",   {31'd0, bus.HRQ}, 32'd0);
    check("rst_dack",  {28'd0, bus.DACK}, 32'd0);
    check("rst_order", {24'd0, bus.priorityOrder}, 32'hE4);

    // Fixed priority: ch1 keeps winning, order pinned.
    bus.DREQ = 4'b1010;
    step();
    check("fix_hrq", {31'd0, bus.HRQ}, 32'd1);
    step(2);
    bus.HLDA = 1'b1;
    step();
    check("fix_dack", {28'd0, bus.DACK}, 32'b0010);
    for (int k = 0; k < 2; k++) begin
      bus.serviceDone = 1'b1;
      step();
      bus.serviceDone = 1'b0;
      check("fix_rel_dack", {28'd0, bus.DACK}, 32'd0);
      check("fix_order", {24'd0, bus.priorityOrder}, 32'hE4);
      step();
      check("fix_regrant", {28'd0, bus.DACK}, 32'b0010);
    end
    quiesce();

    // Rotating priority walk.
    bus.priorityType = 1'b1;
    bus.DREQ = 4'b1111;
    bus.HLDA = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_grant(8);
      check("rot_dack", {28'd0, bus.DACK}, {28'd0, rot_seq[k]});
      bus.serviceDone = 1'b1;
      step();
      bus.serviceDone = 1'b0;
      if (k == 0) check("rot_order", {24'd0, bus.priorityOrder}, 32'b00_11_10_01);
    end
    quiesce();

    // Masking.
    bus.priorityType = 1'b0;
    step();
    bus.DREQ = 4'b0011; bus.maskReg = 4'b0001; bus.HLDA = 1'b1;
    wait_grant(8);
    check("mask_dack", {28'd0, bus.DACK}, 32'b0010);
    bus.maskReg = 4'b0011;
    bus.serviceDone = 1'b1;
    step();
    bus.serviceDone = 1'b0;
    check("mask_rel_hrq", {31'd0, bus.HRQ}, 32'd1);
    step();
    check("mask_idle_hrq", {31'd0, bus.HRQ}, 32'd0);
    quiesce();

    // Withdrawal in REQ, then HLDA abort during a grant (no rotation).
    bus.priorityType = 1'b1;
    bus.DREQ = 4'b0100;
    step();
    check("wd_hrq", {31'd0, bus.HRQ}, 32'd1);
    bus.DREQ = 4'b0000;
    step();
    check("wd_hrq_drop", {31'd0, bus.HRQ}, 32'd0);
    bus.DREQ = 4'b0100; bus.HLDA = 1'b1;
    wait_grant(8);
    check("ab_dack", {28'd0, bus.DACK}, 32'b0100);
    bus.HLDA = 1'b0;
    step();
    check("ab_dack_drop", {28'd0, bus.DACK}, 32'd0);
    check("ab_order", {24'd0, bus.priorityOrder}, 32'hE4);

    // EOP together with serviceDone on a ch2 grant: one rotation.
    bus.HLDA = 1'b1;
    wait_grant(8);
    check("eop_dack", {28'd0, bus.DACK}, 32'b0100);
    bus.EOP_N = 1'b0; bus.serviceDone = 1'b1;
    step();
    bus.EOP_N = 1'b1; bus.serviceDone = 1'b0;
    check("eop_dack_drop", {28'd0, bus.DACK}, 32'd0);
    check("eop_order", {24'd0, bus.priorityOrder}, 32'b10_01_00_11);
    quiesce();

    // Asynchronous reset mid-grant.
    bus.priorityType = 1'b0;
    bus.DREQ = 4'b0010; bus.HLDA = 1'b1;
    wait_grant(8);
    check("rg_dack", {28'd0, bus.DACK}, 32'b0010);
    #2 rst_n = 1'b0;
    #1;
    check("rg_dack_async", {28'd0, bus.DACK}, 32'd0);
    check("rg_hrq_async", {31'd0, bus.HRQ}, 32'd0);
    step(2);
    rst_n = 1'b1;
    bus.DREQ = 4'b0000; bus.HLDA = 1'b0;
    check("rg_order", {24'd0, bus.priorityOrder}, 32'hE4);
    check("rg_valid", {31'd0, bus.grantValid}, 32'd0);

    // Randomized run; the compare process checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3) == 0) bus.DREQ = 4'($urandom);
      bus.maskReg      = ($urandom_range(3) == 0) ? 4'($urandom) : 4'b0000;
      bus.HLDA         = ($urandom_range(4) != 0) ? bus.HRQ : 1'($urandom);
      bus.serviceDone  = bus.grantValid && ($urandom_range(2) == 0);
      bus.EOP_N        = ($urandom_range(15) != 0);
      if ($urandom_range(63) == 0) bus.priorityType = ~bus.priorityType;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
